cpu_prog_loader: RTL and testbench

- Program-load stage directly upstream of the 8-bit CPU core in the TinyTapeout top.
- Receives program bytes from the dedicated input pins, qualified by a pad-level strobe, into a small on-chip program memory.
- Gates the core's run enable.
- Serves registered byte reads to the core's fetch stage once loading ends.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/strobe_sync_edge.sv | 29 ++
 rtl/cpu_prog_loader.sv | 122 ++++++++++++
 tb/tb_cpu_prog_loader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: word size, default program memory size and
// the program loader state encoding.
package cpu_pkg;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned PROG_ADDR_W = 4;

    typedef enum logic [1:0] {
        LDR_IDLE = 2'd0,
        LDR_LOAD = 2'd1,
        LDR_RUN  = 2'd2
    } ldr_state_t;

endpackage

// File: rtl/strobe_sync_edge.sv
// Two-flop synchronizer for an asynchronous pad strobe followed by a
// rising-edge detector producing a single-cycle pulse.
module strobe_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic i_strobe,
    output logic o_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_edge;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_edge  <= 1'b0;
        end else if (ena) begin
            r_sync1 <= i_strobe;
            r_sync2 <= r_sync1;
            r_edge  <= r_sync2;
        end
    end

    assign o_pulse = r_sync2 & ~r_edge;

endmodule

// File: rtl/cpu_prog_loader.sv
// Program-load stage ahead of the 8-bit core: strobed byte loading into a
// small register-array memory, run gating and registered fetch reads.
// Optional running checksum enabled by defining CPU_PROG_LOADER_CHECKSUM_EN.
module cpu_prog_loader
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = PROG_ADDR_W,
    parameter int unsigned DATA_W = cpu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              load_mode,
    input  logic              din_strobe,
    input  logic [DATA_W-1:0] din,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_data,
    output logic              cpu_run,
    output logic [ADDR_W:0]   load_count,
    output logic              overflow,
    output logic [DATA_W-1:0] checksum
);

    localparam int unsigned   DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    ldr_state_t        r_state;
    ldr_state_t        w_state_nxt;
    logic              r_cpu_run;
    logic [DATA_W-1:0] r_cpu_data;
    logic [ADDR_W:0]   r_load_count;
    logic              r_overflow;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_pulse;
    logic w_enter_load;
    logic w_stay_load;
    logic w_full;
    logic w_wr_ok;
    logic w_wr_full;

    strobe_sync_edge u_strobe (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .i_strobe (din_strobe),
        .o_pulse  (w_pulse)
    );

    // Pulses coinciding with any state change are dropped: only a cycle that
    // both starts and stays in LOAD may write.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            LDR_IDLE: w_state_nxt = load_mode ? LDR_LOAD : LDR_RUN;
            LDR_LOAD: if (!load_mode) w_state_nxt = LDR_RUN;
            LDR_RUN:  if (load_mode)  w_state_nxt = LDR_LOAD;
            default:  w_state_nxt = LDR_IDLE;
        endcase
        w_enter_load = (r_state != LDR_LOAD) && (w_state_nxt == LDR_LOAD);
        w_stay_load  = (r_state == LDR_LOAD) && (w_state_nxt == LDR_LOAD);
        w_full       = (r_load_count == FULL_CNT);
        w_wr_ok      = w_stay_load && w_pulse && !w_full;
        w_wr_full    = w_stay_load && w_pulse && w_full;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= LDR_IDLE;
            r_cpu_run    <= 1'b0;
            r_cpu_data   <= '0;
            r_load_count <= '0;
            r_overflow   <= 1'b0;
        end else if (ena) begin
            r_state    <= w_state_nxt;
            r_cpu_run  <= (w_state_nxt == LDR_RUN);
            r_cpu_data <= r_mem[cpu_addr];
            if (w_enter_load) begin
                r_load_count <= '0;
                r_overflow   <= 1'b0;
            end else if (w_wr_ok) begin
                r_load_count <= r_load_count + 1'b1;
            end else if (w_wr_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem <= '{default: '0};
        end else if (ena && w_wr_ok) begin
            r_mem[r_load_count[ADDR_W-1:0]] <= din;
        end
    end

`ifdef CPU_PROG_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (ena) begin
            if (w_enter_load) begin
                r_checksum <= '0;
            end else if (w_wr_ok) begin
                r_checksum <= {r_checksum[DATA_W-2:0], r_checksum[DATA_W-1]} ^ din;
            end
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

    assign cpu_data   = r_cpu_data;
    assign cpu_run    = r_cpu_run;
    assign load_count = r_load_count;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_cpu_prog_loader.sv
// Directed plus randomized bench for cpu_prog_loader against a transaction-level
// model of program memory, load counter, overflow flag and checksum.
module tb_cpu_prog_loader;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 16;
`ifdef CPU_PROG_LOADER_CHECKSUM_EN
    localparam bit CKS_EN = 1'b1;
`else
    localparam bit CKS_EN = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              ena;
    logic              load_mode;
    logic              din_strobe;
    logic [DATA_W-1:0] din;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data;
    logic              cpu_run;
    logic [ADDR_W:0]   load_count;
    logic              overflow;
    logic [DATA_W-1:0] checksum;

    cpu_prog_loader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .load_mode  (load_mode),
        .din_strobe (din_strobe),
        .din        (din),
        .cpu_addr   (cpu_addr),
        .cpu_data   (cpu_data),
        .cpu_run    (cpu_run),
        .load_count (load_count),
        .overflow   (overflow),
        .checksum   (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int unsigned m_mem [DEPTH];
    int unsigned m_count;
    bit          m_ovf;
    bit          m_run;
    bit          m_loading;
    int unsigned m_cks;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int unsigned cks_next(input int unsigned c, input int unsigned d);
        if (!CKS_EN) return 0;
        return (((c * 2) % 256) + (c / 128)) ^ d;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".run"},   32'(cpu_run),    32'(m_run));
        check({tag, ".count"}, 32'(load_count), m_count);
        check({tag, ".ovf"},   32'(overflow),   32'(m_ovf));
        check({tag, ".cks"},   32'(checksum),   m_cks);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        ena        = 1'b1;
        din_strobe = 1'b0;
        tick();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        m_count = 0; m_ovf = 0; m_run = 0; m_loading = 0; m_cks = 0;
        check_outputs("reset");
        check("reset.data", 32'(cpu_data), 32'd0);
        rst = 1'b0;
    endtask

    task automatic set_mode(input bit m);
        load_mode = m;
        tick();
        if (m && !m_loading) begin
            m_loading = 1; m_count = 0; m_ovf = 0; m_cks = 0;
        end
        if (!m) m_loading = 0;
        m_run = !m;
        check_outputs(m ? "mode_load" : "mode_run");
    endtask

    task automatic send_byte(input int unsigned b, input bit exit_at_pulse);
        din        = 8'(b);
        din_strobe = 1'b1;
        tick();
        check("edge0.count", 32'(load_count), m_count);
        tick();
        check("edge1.count", 32'(load_count), m_count);
        if (exit_at_pulse) load_mode = 1'b0;
        tick();
        if (exit_at_pulse) begin
            m_loading = 0; m_run = 1;
        end else if (m_loading) begin
            if (m_count < DEPTH) begin
                m_mem[m_count] = b;
                m_count++;
                m_cks = cks_next(m_cks, b);
            end else begin
                m_ovf = 1;
            end
        end
        check_outputs("pulse");
        tick();
        din_strobe = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        din = 8'($urandom);
    endtask

    task automatic read_check(input int unsigned addr);
        cpu_addr = 4'(addr);
        tick();
        check("read", 32'(cpu_data), m_mem[addr]);
    endtask

    task automatic read_all();
        for (int unsigned a = 0; a < DEPTH; a++) read_check(a);
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; load_mode = 1'b0;
        din_strobe = 1'b0; din = '0; cpu_addr = '0;
        @(negedge clk);

        // Reset, then run straight away
        do_reset();
        check("reset.run_low", 32'(cpu_run), 32'd0);
        set_mode(1'b0);
        read_all();

        // Short load and fetch
        set_mode(1'b1);
        send_byte(32'hA9, 1'b0);
        send_byte(32'h05, 1'b0);
        send_byte(32'h3C, 1'b0);
        check("load3.count", 32'(load_count), 32'd3);
        set_mode(1'b0);
        read_check(1);
        check("fetch1", 32'(cpu_data), 32'h05);

        // Checksum sequence
        set_mode(1'b1);
        send_byte(32'h01, 1'b0);
        check("cks.first", 32'(checksum), CKS_EN ? 32'h01 : 32'h00);
        send_byte(32'h02, 1'b0);
        check("cks.second", 32'(checksum), 32'h00);

        // Fill past capacity
        set_mode(1'b0);
        set_mode(1'b1);
        for (int unsigned i = 0; i <= DEPTH; i++) send_byte(i, 1'b0);
        check("full.count", 32'(load_count), 32'd16);
        check("full.ovf", 32'(overflow), 32'd1);
        read_check(15);
        check("full.last", 32'(cpu_data), 32'h0F);
        read_all();

        // Strobes in RUN are ignored; re-entry clears counters only
        set_mode(1'b0);
        send_byte(32'hFF, 1'b0);
        read_all();
        set_mode(1'b1);
        read_all();

        // Freeze with ena low across a whole strobe pulse
        read_check(5);
        ena = 1'b0;
        din = 8'h77;
        din_strobe = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) din_strobe = 1'b0;
            cpu_addr  = 4'($urandom);
            load_mode = 1'b0;
            tick();
            check_outputs("freeze");
            check("freeze.data", 32'(cpu_data), m_mem[5]);
        end
        load_mode = 1'b1;
        ena = 1'b1;
        tick();
        check_outputs("resume");
        send_byte(32'h5A, 1'b0);
        read_check(0);

        // Pulse on the LOAD->RUN edge is discarded
        send_byte(32'h66, 1'b1);
        read_check(m_count);
        read_all();

        // Randomized sessions
        for (int r = 0; r < 3; r++) begin
            set_mode(1'b1);
            for (int unsigned k = 0, n = $urandom_range(1, 20); k < n; k++)
                send_byte($urandom_range(0, 255), 1'b0);
            set_mode(1'b0);
            for (int k = 0; k < 10; k++) read_check($urandom_range(0, DEPTH - 1));
        end

        // Reset mid-load
        set_mode(1'b1);
        send_byte(32'h11, 1'b0);
        send_byte(32'h22, 1'b0);
        din = 8'h12;
        din_strobe = 1'b1;
        tick();
        do_reset();
        set_mode(1'b0);
        read_all();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
